// File: rtl/simon_96144_core.sv
// Iterative SIMON 96/144 core: one round per clock against a round-key store filled once per key load.
// Define SIMON_DECRYPT_EN to build the decrypt datapath; otherwise enc_dec is ignored and the core always encrypts.
module simon_96144_core #(
  parameter int N  = 48,
  parameter int M  = 3,
  parameter int T  = 54,
  parameter int CO = 6
) (
  input  logic                clk,
  input  logic                nR,
  input  logic                newData,
  input  logic                newKey,
  input  logic                enc_dec,
  input  logic                readData,
  input  logic [2*N-1:0]      plain,
  input  logic [M-1:0][N-1:0] key,
  output logic                ldData,
  output logic                ldKey,
  output logic                doneData,
  output logic                doneKey,
  output logic [2*N-1:0]      cipher
);

  localparam logic [1:0] KIDLE  = 2'd0;
  localparam logic [1:0] KEXP   = 2'd1;
  localparam logic [1:0] KREADY = 2'd2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] REL  = 2'd3;

  localparam logic [CO-1:0] LAST = CO'(T - 1);
  localparam logic [CO-1:0] MW   = CO'(M);

  // Bit j of the z3 sequence is Z3[j] (ascending range keeps the literal readable).
  localparam logic [0:61] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return (v >> s) | (v << (N - s));
  endfunction

  function automatic logic [N-1:0] f_round(input logic [N-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  logic [1:0]      kstate_q, kstate_d;
  logic [CO-1:0]   kcnt_q, kcnt_d;
  logic            ld_key_q, ld_key_d;
  logic            done_key_q, done_key_d;
  logic [N-1:0]    win_q [M];
  logic [N-1:0]    win_d [M];
  logic [N-1:0]    rk_q [T];
  logic [N-1:0]    rk_d [T];

  logic [1:0]      dstate_q, dstate_d;
  logic [CO-1:0]   cnt_q, cnt_d;
  logic            ld_data_q, ld_data_d;
  logic            done_data_q, done_data_d;
  logic [2*N-1:0]  cipher_q, cipher_d;
  logic [N-1:0]    x_q, x_d, y_q, y_d;

  logic            key_start, data_start;
  logic [CO-1:0]   zidx;
  logic [N-1:0]    k_tmp, k_new;
  logic [CO-1:0]   rk_idx;
  logic [N-1:0]    rk_cur;
  logic [N-1:0]    rx, ry;

`ifdef SIMON_DECRYPT_EN
  logic dir_q, dir_d;
  assign rk_idx = dir_q ? cnt_q : LAST - cnt_q;
`else
  logic unused_enc_dec;
  assign unused_enc_dec = enc_dec;
  assign rk_idx = cnt_q;
`endif

  assign rk_cur = rk_q[rk_idx];

  // Key loads wait out a running block; a simultaneous data request yields to the key.
  assign key_start  = newKey && (dstate_q != RUN) && (kstate_q != KEXP);
  assign data_start = (dstate_q == IDLE) && newData && done_key_q && !key_start;

  // Window holds k_{i-3}, k_{i-2}, k_{i-1} so expansion never reads the store.
  always_comb begin
    zidx  = kcnt_q - MW;
    k_tmp = ror(win_q[M-1], 3);
    k_tmp = k_tmp ^ ror(k_tmp, 1);
    k_new = ~win_q[0] ^ k_tmp ^ {{(N-1){1'b0}}, Z3[zidx]} ^ N'(3);
  end

  always_comb begin
    rx = y_q ^ f_round(x_q) ^ rk_cur;
    ry = x_q;
`ifdef SIMON_DECRYPT_EN
    if (!dir_q) begin
      rx = y_q;
      ry = x_q ^ f_round(y_q) ^ rk_cur;
    end
`endif
  end

  always_comb begin
    kstate_d   = kstate_q;
    kcnt_d     = kcnt_q;
    ld_key_d   = 1'b0;
    done_key_d = done_key_q;
    win_d      = win_q;
    rk_d       = rk_q;

    case (kstate_q)
      KIDLE, KREADY: begin
        if (key_start) begin
          for (int j = 0; j < M; j++) begin
            win_d[j] = key[j];
            rk_d[j]  = key[j];
          end
          kcnt_d     = MW;
          ld_key_d   = 1'b1;
          done_key_d = 1'b0;
          kstate_d   = KEXP;
        end
      end
      KEXP: begin
        rk_d[kcnt_q] = k_new;
        for (int j = 0; j < M - 1; j++) win_d[j] = win_q[j+1];
        win_d[M-1] = k_new;
        kcnt_d     = kcnt_q + 1'b1;
        if (kcnt_q == LAST) begin
          kstate_d   = KREADY;
          done_key_d = 1'b1;
        end
      end
      default: kstate_d = KIDLE;
    endcase
  end

  always_comb begin
    dstate_d    = dstate_q;
    cnt_d       = cnt_q;
    ld_data_d   = 1'b0;
    done_data_d = done_data_q;
    cipher_d    = cipher_q;
    x_d         = x_q;
    y_d         = y_q;
`ifdef SIMON_DECRYPT_EN
    dir_d       = dir_q;
`endif

    case (dstate_q)
      IDLE: begin
        if (data_start) begin
          x_d       = plain[2*N-1:N];
          y_d       = plain[N-1:0];
`ifdef SIMON_DECRYPT_EN
          dir_d     = enc_dec;
`endif
          cnt_d     = '0;
          ld_data_d = 1'b1;
          dstate_d  = RUN;
        end
      end
      RUN: begin
        x_d   = rx;
        y_d   = ry;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cipher_d    = {rx, ry};
          done_data_d = 1'b1;
          dstate_d    = DONE;
        end
      end
      DONE: begin
        if (readData) begin
          done_data_d = 1'b0;
          dstate_d    = REL;
        end
      end
      REL: begin
        if (!readData) dstate_d = IDLE;
      end
      default: dstate_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nR) begin
      kstate_q    <= KIDLE;
      kcnt_q      <= '0;
      ld_key_q    <= 1'b0;
      done_key_q  <= 1'b0;
      dstate_q    <= IDLE;
      cnt_q       <= '0;
      ld_data_q   <= 1'b0;
      done_data_q <= 1'b0;
      cipher_q    <= '0;
    end else begin
      kstate_q    <= kstate_d;
      kcnt_q      <= kcnt_d;
      ld_key_q    <= ld_key_d;
      done_key_q  <= done_key_d;
      dstate_q    <= dstate_d;
      cnt_q       <= cnt_d;
      ld_data_q   <= ld_data_d;
      done_data_q <= done_data_d;
      cipher_q    <= cipher_d;
    end
  end

  // Datapath state carries no reset; doneKey/doneData gate its validity.
  always_ff @(posedge clk) begin
    rk_q  <= rk_d;
    win_q <= win_d;
    x_q   <= x_d;
    y_q   <= y_d;
`ifdef SIMON_DECRYPT_EN
    dir_q <= dir_d;
`endif
  end

  assign ldData   = ld_data_q;
  assign ldKey    = ld_key_q;
  assign doneData = done_data_q;
  assign doneKey  = done_key_q;
  assign cipher   = cipher_q;

endmodule

// File: tb/tb_simon_96144_core.sv
// Bench for simon_96144_core: vector table, handshake sequences and a loop-level SIMON model.
module tb_simon_96144_core;

  localparam logic [143:0] KNOWN_KEY = 144'h151413121110_0D0C0B0A0908_050403020100;
  localparam logic [95:0]  KNOWN_PT  = 96'h74616874207473756420666F;
  localparam logic [95:0]  KNOWN_CT  = 96'hECAD1C6C451E3F59C5DB1AE9;

  logic             clk;
  logic             nR;
  logic             newData;
  logic             newKey;
  logic             enc_dec;
  logic             readData;
  logic [95:0]      plain;
  logic [2:0][47:0] key_w;
  logic             ldData;
  logic             ldKey;
  logic             doneData;
  logic             doneKey;
  logic [95:0]      cipher;

  simon_96144_core dut (
    .clk      (clk),
    .nR       (nR),
    .newData  (newData),
    .newKey   (newKey),
    .enc_dec  (enc_dec),
    .readData (readData),
    .plain    (plain),
    .key      (key_w),
    .ldData   (ldData),
    .ldKey    (ldKey),
    .doneData (doneData),
    .doneKey  (doneKey),
    .cipher   (cipher)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ld_data_cnt = 0;
  int ld_key_cnt = 0;

  always @(posedge clk) begin
    if (ldData) ld_data_cnt <= ld_data_cnt + 1;
    if (ldKey)  ld_key_cnt  <= ld_key_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  string z3 = "11011011101011000110010111100000010010001010011100110100001111";
  logic [47:0] mrk [54];

  function automatic logic [47:0] rotr(input logic [47:0] v, input int s);
    return (v >> s) | (v << (48 - s));
  endfunction

  function automatic logic [47:0] rotl(input logic [47:0] v, input int s);
    return (v << s) | (v >> (48 - s));
  endfunction

  function automatic logic [47:0] fmix(input logic [47:0] v);
    return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
  endfunction

  task automatic model_expand(input logic [143:0] k);
    logic [47:0] t;
    logic        zb;
    for (int i = 0; i < 3; i++) mrk[i] = k[48*i +: 48];
    for (int i = 3; i < 54; i++) begin
      t  = rotr(mrk[i-1], 3);
      t  = t ^ rotr(t, 1);
      zb = (z3[i-3] == "1");
      mrk[i] = ~mrk[i-3] ^ t ^ {47'd0, zb} ^ 48'd3;
    end
  endtask

  function automatic logic [95:0] model_crypt(input logic [95:0] blk, input bit enc);
    logic [47:0] x, y, tmp;
    x = blk[95:48];
    y = blk[47:0];
    if (enc) begin
      for (int i = 0; i < 54; i++) begin
        tmp = x;
        x = y ^ fmix(x) ^ mrk[i];
        y = tmp;
      end
    end else begin
      for (int i = 53; i >= 0; i--) begin
        tmp = y;
        y = x ^ fmix(y) ^ mrk[i];
        x = tmp;
      end
    end
    return {x, y};
  endfunction

  function automatic bit eff_enc(input bit e);
`ifdef SIMON_DECRYPT_EN
    return e;
`else
    return 1'b1;
`endif
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic load_key(input logic [143:0] k, output int lat);
    bit ok;
    int k0;
    k0 = ld_key_cnt;
    key_w  = k;
    newKey = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ldKey) begin ok = 1'b1; break; end
    end
    newKey = 1'b0;
    check("ldKey seen", 96'(ok), 96'd1);
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      lat++;
      if (doneKey) begin ok = 1'b1; break; end
    end
    check("doneKey seen", 96'(ok), 96'd1);
    check("ldKey pulses", 96'(ld_key_cnt - k0), 96'd1);
  endtask

  task automatic run_block(input logic [95:0] pt, input bit e, output logic [95:0] ct, output int lat);
    bit ok;
    plain   = pt;
    enc_dec = e;
    newData = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ldData) begin ok = 1'b1; break; end
    end
    newData = 1'b0;
    check("ldData seen", 96'(ok), 96'd1);
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      lat++;
      if (doneData) begin ok = 1'b1; break; end
    end
    check("doneData seen", 96'(ok), 96'd1);
    ct = cipher;
    readData = 1'b1;
    step();
    check("doneData after readData", 96'(doneData), 96'd0);
    readData = 1'b0;
    step();
  endtask

  typedef struct {
    logic [143:0] k;
    logic [95:0]  pt;
    bit           enc;
    logic [95:0]  exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [143:0] cur_key;
    logic [95:0]  ct, pt, exp;
    int           lat, d0;
    bit           ok;

    nR = 1'b1; newData = 1'b0; newKey = 1'b0; enc_dec = 1'b1; readData = 1'b0;
    plain = '0; key_w = '0;

    // Vector table: known-answer entries plus random entries scored by the model.
    vecs[0] = '{KNOWN_KEY, KNOWN_PT, 1'b1, KNOWN_CT};
    model_expand(KNOWN_KEY);
`ifdef SIMON_DECRYPT_EN
    vecs[1] = '{KNOWN_KEY, KNOWN_CT, 1'b0, KNOWN_PT};
`else
    vecs[1] = '{KNOWN_KEY, KNOWN_CT, 1'b0, model_crypt(KNOWN_CT, 1'b1)};
`endif
    for (int v = 2; v < 6; v++) begin
      vecs[v].k   = {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
      vecs[v].pt  = {$urandom(), $urandom(), $urandom()};
      vecs[v].enc = ($urandom_range(0, 1) == 1);
      model_expand(vecs[v].k);
      vecs[v].exp = model_crypt(vecs[v].pt, eff_enc(vecs[v].enc));
    end

    // Reset state
    repeat (3) step();
    check("reset ldData", 96'(ldData), 96'd0);
    check("reset ldKey", 96'(ldKey), 96'd0);
    check("reset doneData", 96'(doneData), 96'd0);
    check("reset doneKey", 96'(doneKey), 96'd0);
    check("reset cipher", cipher, 96'd0);
    nR = 1'b0;

    // newData before any key: no load; then key loads first while newData stays high
    plain = KNOWN_PT; enc_dec = 1'b1; newData = 1'b1;
    repeat (8) step();
    check("no ldData without key", 96'(ld_data_cnt), 96'd0);
    key_w = KNOWN_KEY; newKey = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ldKey) begin ok = 1'b1; break; end
    end
    newKey = 1'b0;
    check("ldKey seen (held newData)", 96'(ok), 96'd1);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      lat++;
      if (doneKey) begin ok = 1'b1; break; end
    end
    check("doneKey seen (held newData)", 96'(ok), 96'd1);
    check("doneKey latency", 96'(lat), 96'd51);
    check("no ldData during expansion", 96'(ld_data_cnt), 96'd0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ldData) begin ok = 1'b1; break; end
    end
    newData = 1'b0;
    check("ldData after doneKey", 96'(ok), 96'd1);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      lat++;
      if (doneData) begin ok = 1'b1; break; end
    end
    check("doneData seen (first)", 96'(ok), 96'd1);
    check("doneData latency", 96'(lat), 96'd54);
    check("known cipher", cipher, KNOWN_CT);
    readData = 1'b1; step();
    readData = 1'b0; step();
    cur_key = KNOWN_KEY;

    // Table-driven vectors
    foreach (vecs[v]) begin
      if (vecs[v].k !== cur_key) begin
        load_key(vecs[v].k, lat);
        check($sformatf("vec%0d key latency", v), 96'(lat), 96'd51);
        cur_key = vecs[v].k;
      end
      run_block(vecs[v].pt, vecs[v].enc, ct, lat);
      check($sformatf("vec%0d cipher", v), ct, vecs[v].exp);
      check($sformatf("vec%0d latency", v), 96'(lat), 96'd54);
      check($sformatf("vec%0d cipher held", v), cipher, vecs[v].exp);
    end

    // Stream of 5 blocks with full handshake
    model_expand(cur_key);
    d0 = ld_data_cnt;
    for (int b = 0; b < 5; b++) begin
      pt  = {$urandom(), $urandom(), $urandom()};
      exp = model_crypt(pt, 1'b1);
      run_block(pt, 1'b1, ct, lat);
      check($sformatf("stream%0d cipher", b), ct, exp);
    end
    check("stream ldData pulses", 96'(ld_data_cnt - d0), 96'd5);

    // Reset mid-RUN aborts everything and invalidates the key store
    plain = {$urandom(), $urandom(), $urandom()}; enc_dec = 1'b1; newData = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ldData) begin ok = 1'b1; break; end
    end
    newData = 1'b0;
    check("ldData before abort", 96'(ok), 96'd1);
    repeat (10) step();
    nR = 1'b1;
    step();
    check("abort ldData", 96'(ldData), 96'd0);
    check("abort ldKey", 96'(ldKey), 96'd0);
    check("abort doneData", 96'(doneData), 96'd0);
    check("abort doneKey", 96'(doneKey), 96'd0);
    check("abort cipher", cipher, 96'd0);
    nR = 1'b0;
    d0 = ld_data_cnt;
    newData = 1'b1;
    repeat (70) step();
    newData = 1'b0;
    check("no ldData after abort", 96'(ld_data_cnt - d0), 96'd0);
    check("doneData stays low after abort", 96'(doneData), 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_96144_core.md
# simon_96144_core

Iterative SIMON 96/144 block cipher core: 96-bit block, 144-bit key, 54 rounds, one round per clock. Key expansion runs once per key load and fills an internal round-key store. Blocks are then encrypted or decrypted against that store. The core sits behind a simple level-based load/done/read handshake driven by a host controller.

## Interface
- N, 48, word size (half block)
- M, 3, key words
- T, 54, rounds
- Co, 6, round/key counter width (2^Co ≥ T)
- clk  in  1  clock; all logic on rising edge
- nR  in  1  reset, synchronous, active-high (nR=1 resets)
- newData  in  1  host requests block load (level)
- newKey  in  1  host requests key load (level)
- enc_dec  in  1  1=encrypt, 0=decrypt; sampled with plain
- readData  in  1  host has taken cipher (level)
- plain  in  2N  input block; [2N-1:N]=x (left), [N-1:0]=y
- key  in  M×N packed  key[0]=k0 (first round key) … key[M-1]
- ldData  out  1  one-cycle pulse: plain captured
- ldKey  out  1  one-cycle pulse: key captured
- doneData  out  1  cipher valid (level)
- doneKey  out  1  round-key store complete (level)
- cipher  out  2N  result block, same x/y layout

## Operation
- Round function f(x) = (x<<<1 & x<<<8) ^ (x<<<2), rotations within N bits.
- Encrypt round i=0..T-1: x' = y ^ f(x) ^ k_i, y' = x.
- Decrypt round i=T-1..0: y' = x ^ f(y) ^ k_i, x' = y.
- Key schedule, i=M..T-1: t = k_{i-1}>>>3; t = t ^ (t>>>1); k_i = ~k_{i-3} ^ t ^ z3[(i-M) mod 62] ^ 3.
- z3 (bit for j=0 first): 11011011101011000110010111100000010010001010011100110100001111.
- Round keys held in a T×N register array.
- Key FSM: KIDLE → (newKey=1, data FSM not RUN) capture k0..k2, pulse ldKey, clear doneKey → KEXP (T-M cycles, one k_i per cycle) → KREADY (doneKey=1) → newKey reloads. newKey during data RUN is deferred until RUN ends.
- Data FSM:
  - IDLE → (newData=1 and doneKey=1) capture plain and enc_dec, pulse ldData → RUN.
  - RUN: T cycles, counter 0..T-1 (decrypt indexes key store T-1-count).
  - DONE: cipher loaded, doneData=1; on readData=1 → REL with doneData=0.
  - REL → readData=0 → IDLE.
- newData is level-sampled only in IDLE; host must drop it before doneData rises.
- cipher register holds the last result until the next result overwrites it.

## Timing
- Reset: all FSMs idle, ldData=ldKey=doneData=doneKey=0, cipher=0, key store invalid. Reset mid-operation aborts everything; a new key load is required.
- ldKey high the cycle after the capture edge. doneKey rises T-M=51 cycles after ldKey.
- ldData high the cycle after the capture edge. doneData rises T=54 cycles after ldData.
- Back-to-back: the next block can load on the first IDLE cycle after readData falls. Minimum throughput is T+3 cycles/block plus host handshake.
- Simultaneous newData and newKey in idle with doneKey=0: key loads first; data waits for doneKey.
- readData held high while in DONE or REL has no further effect.

## Configuration
- SIMON_DECRYPT_EN defined: enc_dec selects direction as above.
- SIMON_DECRYPT_EN undefined: decrypt datapath and reverse key indexing are removed, enc_dec is ignored, and the core always encrypts.

## Test plan
- Reset, then load key 151413121110_0D0C0B0A0908_050403020100 → ldKey pulses once; doneKey rises 51 cycles later.
- Encrypt plain 74616874207473756420666F → doneData 54 cycles after ldData; cipher=ECAD1C6C451E3F59C5DB1AE9.
- Decrypt (enc_dec=0) ECAD1C6C451E3F59C5DB1AE9 → cipher=74616874207473756420666F (SIMON_DECRYPT_EN defined).
- Stream 5 blocks with full handshake (newData level, readData after doneData, drop after doneData falls) → exactly 5 ldData pulses; each cipher matches the software model.
- Assert newData before any key load → no ldData until doneKey=1.
- Assert nR mid-RUN → all outputs 0 next cycle; newData without a new key produces no ldData.
